// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the command-coded RAM.
// Turns MOSI frames into {cmd,payload} words on rx_data/rx_valid and
// serialises RAM read data back out on MISO. clk is the SPI clock (SCLK).
module spi_slave_ctrl #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int RXW = ADDR_SIZE + 2;
  localparam int CW  = $clog2(RXW + 1);
  localparam int TW  = $clog2(ADDR_SIZE + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(RXW - 1);
  localparam logic [CW-1:0] WORD_DONE = CW'(RXW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_CMD,
    S_WRITE,
    S_READ_ADD,
    S_READ_DATA
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_bit_cnt;
  // Only the first RXW-1 bits need storing; the last bit goes straight to rx_data.
  logic [RXW-2:0]      r_shreg;
  logic                r_rd_addr_seen;
  logic                r_tx_valid_d;
  logic [ADDR_SIZE-1:0] r_tx_sh;
  logic [TW-1:0]       r_tx_cnt;

  logic w_shift_st;
  logic w_sample;
  logic w_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; SS_n high drops any frame back to IDLE
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && SS_n) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    w_next = SS_n ? S_IDLE : S_CHK_CMD;
        S_CHK_CMD: begin
          if (!MOSI)               w_next = S_WRITE;
          else if (r_rd_addr_seen) w_next = S_READ_DATA;
          else                     w_next = S_READ_ADD;
        end
        default:   w_next = r_state;
      endcase
    end
  end

  // Per-state control strobes for the receive datapath
  always_comb begin
    w_shift_st = (r_state == S_WRITE) || (r_state == S_READ_ADD) ||
                 (r_state == S_READ_DATA);
    w_sample   = w_shift_st && !SS_n && (r_bit_cnt != WORD_DONE);
    w_last     = w_sample && (r_bit_cnt == LAST_BIT);
  end

  // Receive shifter, word strobe and read-address bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= '0;
      r_shreg        <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= w_last;
      if (!w_shift_st || SS_n) r_bit_cnt <= '0;
      else if (w_sample)       r_bit_cnt <= r_bit_cnt + CW'(1);
      if (w_sample) r_shreg <= {r_shreg[RXW-3:0], MOSI};
      if (w_last) begin
        rx_data <= {r_shreg, MOSI};
        if (r_state == S_READ_ADD)  r_rd_addr_seen <= 1'b1;
        if (r_state == S_READ_DATA) r_rd_addr_seen <= 1'b0;
      end
    end
  end

  // Read-data return: RAM strobe is only honoured right after a READ_DATA word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid_d <= 1'b0;
      r_tx_sh      <= '0;
      r_tx_cnt     <= '0;
      MISO         <= 1'b0;
    end else if (SS_n || r_state != S_READ_DATA) begin
      r_tx_valid_d <= 1'b0;
      r_tx_sh      <= '0;
      r_tx_cnt     <= '0;
      MISO         <= 1'b0;
    end else begin
      r_tx_valid_d <= tx_valid && rx_valid;
      if (r_tx_valid_d) begin
        MISO     <= tx_data[ADDR_SIZE-1];
        r_tx_sh  <= {tx_data[ADDR_SIZE-2:0], 1'b0};
        r_tx_cnt <= TW'(ADDR_SIZE - 1);
      end else if (r_tx_cnt != '0) begin
        MISO     <= r_tx_sh[ADDR_SIZE-1];
        r_tx_sh  <= {r_tx_sh[ADDR_SIZE-2:0], 1'b0};
        r_tx_cnt <= r_tx_cnt - TW'(1);
      end else begin
        MISO     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: the driver pushes expected MISO
// per edge and expected rx words; a negedge monitor pops and compares.
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;
  logic       q_miso[$];
  logic [9:0] q_rx[$];
  bit         mon_en = 1'b0;

  spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against scoreboard entries
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_miso.size() > 0) begin
        logic e;
        e = q_miso.pop_front();
        checks++;
        if (MISO !== e) begin
          errors++;
          $display("FAIL miso t=%0t got %b exp %b", $time, MISO, e);
        end
      end
      if (rx_valid === 1'b1) begin
        checks++;
        if (q_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected t=%0t got rx_valid=1 rx_data=%h exp none", $time, rx_data);
        end else begin
          logic [9:0] w;
          w = q_rx.pop_front();
          if (rx_data !== w) begin
            errors++;
            $display("FAIL rx_data t=%0t got %h exp %h", $time, rx_data, w);
          end
        end
      end else if (q_rx.size() > 0) begin
        logic [9:0] w;
        w = q_rx.pop_front();
        checks++;
        errors++;
        $display("FAIL rx_missing t=%0t got rx_valid=%b exp word %h", $time, rx_valid, w);
      end
    end
  end

  task automatic step(input logic ss, input logic mosi, input logic txv,
                      input logic [7:0] txd, input logic exp);
    SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    @(posedge clk);
    q_miso.push_back(exp);
    #1;
  endtask

  task automatic direct(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // One SPI frame: E0, command bit, nbits word bits, then read-data window
  task automatic frame(input logic first, input logic [9:0] word, input int nbits,
                       input logic rd, input logic [7:0] txd, input logic txv,
                       input logic rst_mid);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, first, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      step(1'b0, word[9-i], 1'b0, 8'h00, 1'b0);
      if (i == 9) q_rx.push_back(word);
    end
    if (nbits < 10) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      return;
    end
    step(1'b0, 1'b0, txv, txd, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (rst_mid && k == 3) begin
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        direct("rst_miso", {9'd0, MISO}, 10'd0);
        direct("rst_rx_valid", {9'd0, rx_valid}, 10'd0);
        direct("rst_rx_data", rx_data, 10'd0);
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        return;
      end
      step(1'b0, 1'b0, 1'b0, txd, rd ? txd[7-k] : 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, txd, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    #12;
    direct("reset_miso", {9'd0, MISO}, 10'd0);
    direct("reset_rx_valid", {9'd0, rx_valid}, 10'd0);
    direct("reset_rx_data", rx_data, 10'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // write address, write data
    frame(1'b0, 10'h0A5, 10, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(1'b0, 10'h13C, 10, 1'b0, 8'h00, 1'b0, 1'b0);
    // read address then read data
    frame(1'b1, 10'h2A5, 10, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(1'b1, 10'h300, 10, 1'b1, 8'h3C, 1'b1, 1'b0);
    // abort after 5 payload bits, then a normal write
    frame(1'b0, 10'h155, 5, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(1'b0, 10'h0FF, 10, 1'b0, 8'h00, 1'b0, 1'b0);
    // read-data command with no address seen: treated as read address
    frame(1'b1, 10'h3AA, 10, 1'b0, 8'hFF, 1'b1, 1'b0);
    frame(1'b1, 10'h355, 10, 1'b1, 8'hA5, 1'b1, 1'b0);
    // flag was cleared by the read-data word
    frame(1'b1, 10'h3C3, 10, 1'b0, 8'h81, 1'b1, 1'b0);
    frame(1'b1, 10'h3FF, 10, 1'b1, 8'h81, 1'b1, 1'b0);
    // reset mid read-data, flag must be cleared
    frame(1'b1, 10'h211, 10, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(1'b1, 10'h3F0, 10, 1'b1, 8'hFF, 1'b1, 1'b1);
    frame(1'b1, 10'h300, 10, 1'b0, 8'hFF, 1'b1, 1'b0);
    frame(1'b1, 10'h301, 10, 1'b1, 8'h5A, 1'b1, 1'b0);

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (q_rx.size() != 0 || q_miso.size() != 0) begin
      errors++;
      $display("FAIL drain got rx=%0d miso=%0d pending exp 0", q_rx.size(), q_miso.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
